// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-side controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_SETUP = 3'd1,
    S_EN_HI = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_IDLE  = 3'd5
  } lcd_state_e;

  localparam int LCD_INIT_LEN = 7;

  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
  localparam logic [7:0] LCD_CMD_FSET    = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{
    LCD_CMD_FSET, LCD_CMD_FSET, LCD_CMD_FSET, LCD_CMD_FSET,
    LCD_CMD_DISP_ON, LCD_CMD_CLEAR, LCD_CMD_ENTRY
  };

  // Clear/home (and 0x03, which the controller treats as home) need the long wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) &&
           ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module lcd_timer
#(
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] r_cnt;

  // Count down toward zero, or take a new value on load.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      r_cnt <= value_i;
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign zero_o = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: autonomous power-up init, then one byte per
// valid/ready handshake with EN strobe and post-write wait timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int CNT_W          = 20,
  parameter int SETUP_CYC      = 3,
  parameter int EN_HIGH_CYC    = 25,
  parameter int HOLD_CYC       = 3,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int PWRUP_CYC      = 750000,
  parameter int INIT_WAIT1_CYC = 205000,
  parameter int INIT_WAIT2_CYC = 5000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       init_done_o,
  output logic       busy_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o,
  output logic       lcd_blon_o
);

  lcd_state_e       r_state, w_state_nxt;
  logic [2:0]       r_step, w_step_nxt, w_step_inc;
  logic             r_init_done, w_init_done_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_rs, w_rs_nxt;
  logic             r_en, r_on, r_ready, r_busy;
  logic             w_accept, w_zero, w_load, w_last_step;
  logic [CNT_W-1:0] w_wait_cyc, w_load_val;

  assign w_accept    = req_valid_i && r_ready;
  assign w_step_inc  = r_step + 3'd1;
  assign w_last_step = (r_step == 3'(LCD_INIT_LEN - 1));
  assign w_load      = rst_i || (w_state_nxt != r_state);

  lcd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i   (clk_i),
    .load_i  (w_load),
    .value_i (w_load_val),
    .zero_o  (w_zero)
  );

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_PWRUP;
      r_step      <= 3'd0;
      r_init_done <= 1'b0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_on        <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_init_done <= w_init_done_nxt;
      r_data      <= w_data_nxt;
      r_rs        <= w_rs_nxt;
      r_en        <= (w_state_nxt == S_EN_HI);
      r_on        <= 1'b1;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state selection; every timed state leaves when the counter hits zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PWRUP: if (w_zero) w_state_nxt = S_SETUP; else w_state_nxt = S_PWRUP;
      S_SETUP: if (w_zero) w_state_nxt = S_EN_HI; else w_state_nxt = S_SETUP;
      S_EN_HI: if (w_zero) w_state_nxt = S_HOLD;  else w_state_nxt = S_EN_HI;
      S_HOLD:  if (w_zero) w_state_nxt = S_WAIT;  else w_state_nxt = S_HOLD;
      S_WAIT: begin
        if (!w_zero) begin
          w_state_nxt = S_WAIT;
        end else if (r_init_done || w_last_step) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SETUP;
        end
      end
      S_IDLE:  if (w_accept) w_state_nxt = S_SETUP; else w_state_nxt = S_IDLE;
      default: w_state_nxt = S_PWRUP;
    endcase
  end

  // Byte/step/done updates, wait selection and counter reload value.
  always_comb begin
    w_data_nxt      = r_data;
    w_rs_nxt        = r_rs;
    w_step_nxt      = r_step;
    w_init_done_nxt = r_init_done;
    if (r_state == S_PWRUP && w_state_nxt == S_SETUP) begin
      w_step_nxt = 3'd0;
      w_data_nxt = LCD_INIT_SEQ[0];
      w_rs_nxt   = 1'b0;
    end else if (r_state == S_WAIT && w_state_nxt == S_SETUP) begin
      w_step_nxt = w_step_inc;
      w_data_nxt = LCD_INIT_SEQ[w_step_inc];
      w_rs_nxt   = 1'b0;
    end else if (r_state == S_WAIT && w_state_nxt == S_IDLE) begin
      w_init_done_nxt = 1'b1;
    end else if (w_accept) begin
      w_data_nxt = req_data_i;
      w_rs_nxt   = req_rs_i;
    end else begin
      w_init_done_nxt = r_init_done;
    end

    if (!r_init_done && r_step == 3'd0) begin
      w_wait_cyc = CNT_W'(INIT_WAIT1_CYC);
    end else if (!r_init_done && r_step == 3'd1) begin
      w_wait_cyc = CNT_W'(INIT_WAIT2_CYC);
    end else if (is_slow_cmd(r_rs, r_data)) begin
      w_wait_cyc = CNT_W'(CLEAR_WAIT_CYC);
    end else begin
      w_wait_cyc = CNT_W'(CMD_WAIT_CYC);
    end

    // Reset parks the counter one above N-1 so the power-up window
    // starts at the first edge out of reset.
    if (rst_i) begin
      w_load_val = CNT_W'(PWRUP_CYC);
    end else begin
      case (w_state_nxt)
        S_SETUP: w_load_val = CNT_W'(SETUP_CYC - 1);
        S_EN_HI: w_load_val = CNT_W'(EN_HIGH_CYC - 1);
        S_HOLD:  w_load_val = CNT_W'(HOLD_CYC - 1);
        S_WAIT:  w_load_val = w_wait_cyc - CNT_W'(32'd1);
        default: w_load_val = {CNT_W{1'b0}};
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign init_done_o = r_init_done;
  assign lcd_data_o  = r_data;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = r_en;
  assign lcd_on_o    = r_on;
  assign lcd_blon_o  = r_on;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: EN pulses are scored against a queue of
// expected {rs, data, rise cycle}; handshakes check latency and latching.
module tb_lcd_ctrl;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_rs_i = 1'b0;
  logic [7:0] req_data_i = 8'h00;
  logic       req_ready_o, init_done_o, busy_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  logic [7:0] init_b [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         init_w [7] = '{40, 20, 10, 10, 10, 50, 10};

  int   mon_width = 0;
  int   mon_last_fall = 0;
  int   mon_gap = 0;
  logic mon_prev_en = 1'b0;

  lcd_ctrl #(
    .CNT_W(20), .SETUP_CYC(2), .EN_HIGH_CYC(4), .HOLD_CYC(2),
    .CMD_WAIT_CYC(10), .CLEAR_WAIT_CYC(50), .PWRUP_CYC(100),
    .INIT_WAIT1_CYC(40), .INIT_WAIT2_CYC(20)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .req_rs_i(req_rs_i), .req_data_i(req_data_i),
    .init_done_o(init_done_o), .busy_o(busy_o), .lcd_data_o(lcd_data_o),
    .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o),
    .lcd_on_o(lcd_on_o), .lcd_blon_o(lcd_blon_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_exp(input logic rs, input logic [7:0] d, input int rise);
    exp_t e;
    e.rs = rs; e.data = d; e.rise = rise;
    sb_q.push_back(e);
  endtask

  // EN pulse monitor: pops one expectation per rising edge.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      mon_prev_en = 1'b0;
      mon_width   = 0;
    end else begin
      if (lcd_en_o && !mon_prev_en) begin
        mon_gap   = cyc - mon_last_fall;
        mon_width = 1;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected EN pulse: data %0h rs %0b at cycle %0d", lcd_data_o, lcd_rs_o, cyc);
        end else begin
          e = sb_q.pop_front();
          check("en data", {24'h0, lcd_data_o}, {24'h0, e.data});
          check("en rs", {31'h0, lcd_rs_o}, {31'h0, e.rs});
          check("en rise cycle", cyc, e.rise);
          check("rw low", {31'h0, lcd_rw_o}, 32'h0);
        end
      end else if (lcd_en_o) begin
        mon_width++;
      end else if (mon_prev_en) begin
        check("en width", mon_width, 4);
        mon_last_fall = cyc;
      end
      mon_prev_en = lcd_en_o;
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk_i); n++;
      @(negedge clk_i);
    end while (!req_ready_o && n < 2000);
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, {16'h0, req_ready_o, init_done_o, busy_o, lcd_rs_o, lcd_rw_o,
               lcd_en_o, lcd_on_o, lcd_blon_o, lcd_data_o}, 32'h0000_2000);
  endtask

  // Release reset and follow the whole init sequence.
  task automatic do_init(input string nm);
    int t, n;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    t = cyc + 1 + 100;
    for (int i = 0; i < 7; i++) begin
      push_exp(1'b0, init_b[i], t + 2);
      t = t + 8 + init_w[i];
    end
    @(posedge clk_i); @(negedge clk_i);
    check({nm, " lcd_on after release"}, {30'h0, lcd_on_o, lcd_blon_o}, 32'h3);
    check({nm, " not ready early"}, {31'h0, req_ready_o}, 32'h0);
    wait_ready(n);
    check({nm, " init latency"}, n, 306);
    check({nm, " init_done"}, {30'h0, init_done_o, busy_o}, 32'h2);
    check({nm, " init pulses consumed"}, sb_q.size(), 0);
  endtask

  // One handshake from a ready cycle; returns at the next ready cycle.
  task automatic send(input logic rs, input logic [7:0] d, input int lat, input string nm);
    int n;
    req_rs_i = rs; req_data_i = d; req_valid_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    req_valid_i = 1'b0;
    check({nm, " ready drop"}, {30'h0, req_ready_o, busy_o}, 32'h1);
    push_exp(rs, d, cyc + 2);
    wait_ready(n);
    check({nm, " latency"}, n, lat);
    check({nm, " byte held"}, {23'h0, lcd_rs_o, lcd_data_o}, {23'h0, rs, d});
  endtask

  initial begin
    vec_t vecs [8];
    int   n;
    vecs[0] = '{rs: 1'b1, data: 8'h41, lat: 18};
    vecs[1] = '{rs: 1'b0, data: 8'h01, lat: 58};
    vecs[2] = '{rs: 1'b0, data: 8'h80, lat: 18};
    vecs[3] = '{rs: 1'b0, data: 8'h02, lat: 58};
    vecs[4] = '{rs: 1'b0, data: 8'h03, lat: 58};
    vecs[5] = '{rs: 1'b0, data: 8'h00, lat: 18};
    vecs[6] = '{rs: 1'b1, data: 8'h01, lat: 18};
    vecs[7] = '{rs: 1'b0, data: 8'h04, lat: 18};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset values");
    do_init("init");

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].rs, vecs[i].data, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Back-to-back with valid held high.
    req_rs_i = 1'b1; req_data_i = 8'h48; req_valid_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check("b2b first accept", {31'h0, req_ready_o}, 32'h0);
    push_exp(1'b1, 8'h48, cyc + 2);
    req_data_i = 8'h49;
    wait_ready(n);
    check("b2b first latency", n, 18);
    @(posedge clk_i); @(negedge clk_i);
    check("b2b second accept", {31'h0, req_ready_o}, 32'h0);
    push_exp(1'b1, 8'h49, cyc + 2);
    req_valid_i = 1'b0;
    wait_ready(n);
    check("b2b second latency", n, 18);
    check("b2b en low gap", mon_gap, 15);

    // Reset in the middle of an EN pulse.
    req_rs_i = 1'b1; req_data_i = 8'h33; req_valid_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    push_exp(1'b1, 8'h33, cyc + 2);
    req_valid_i = 1'b0;
    n = 0;
    while (!lcd_en_o && n < 50) begin
      @(negedge clk_i); n++;
    end
    check("mid en seen", {31'h0, lcd_en_o}, 32'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    req_valid_i = 1'b1; req_rs_i = 1'b1; req_data_i = 8'h55;
    @(posedge clk_i); @(negedge clk_i);
    check("mid reset en/done", {30'h0, lcd_en_o, init_done_o}, 32'h0);
    check_reset_outputs("mid reset values");
    check("mid reset queue", sb_q.size(), 0);
    do_init("reinit");

    // Valid held through init: accepted only now, later input changes ignored.
    @(posedge clk_i); @(negedge clk_i);
    check("held valid accept", {31'h0, req_ready_o}, 32'h0);
    push_exp(1'b1, 8'h55, cyc + 2);
    req_data_i = 8'hAA;
    req_valid_i = 1'b0;
    wait_ready(n);
    check("held valid latency", n, 18);
    check("held byte latched", {23'h0, lcd_rs_o, lcd_data_o}, {23'h0, 1'b1, 8'h55});
    check("queue drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
